// File: rtl/reg_file_master.sv
// reg_file_master: host-side controller for an 8-entry register file.
// Turns valid/ready burst commands into RF write/read cycles and read responses.
module reg_file_master #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic [ADDR_WIDTH-1:0] RSP_ADDR,
    output logic                  DONE,
    output logic                  BUSY,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RSP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_nxt;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wdata_nxt;

    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;
    logic [ADDR_WIDTH-1:0] rsp_addr_nxt;
    logic                  done_nxt;
    logic                  wr_en_nxt;
    logic                  rd_en_nxt;
    logic [ADDR_WIDTH-1:0] rf_addr_nxt;
    logic [DATA_WIDTH-1:0] rf_wdata_nxt;

    logic accept;
    logic last;
    logic rsp_take;
    logic beat_end;

    assign accept   = (state == IDLE) && CMD_VALID;
    assign last     = (cnt == '0);
    assign rsp_take = (state == RSP) && RSP_READY;
    assign beat_end = (state == WR) || rsp_take;

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);

    // State and burst bookkeeping registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            wdata <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            wdata <= wdata_nxt;
        end
    end

    // Next-state decode: writes stream one beat per cycle, reads loop REQ/WAIT/RSP
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    state_nxt = CMD_WRITE ? WR : RD_REQ;
                end
            end
            WR: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                state_nxt = RSP;
            end
            RSP: begin
                if (RSP_READY) begin
                    state_nxt = last ? IDLE : RD_REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the command on accept, then step address and count per finished beat
    always_comb begin
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        wdata_nxt = wdata;
        if (accept) begin
            addr_nxt  = CMD_ADDR;
            cnt_nxt   = CMD_LEN;
            wdata_nxt = CMD_WDATA;
        end else if (beat_end && !last) begin
            addr_nxt = addr + ADDR_ONE;
            cnt_nxt  = cnt - LEN_ONE;
        end
    end

    // Output decode: values the registered outputs take in the next state
    always_comb begin
        wr_en_nxt     = (state_nxt == WR);
        rd_en_nxt     = (state_nxt == RD_REQ);
        rf_addr_nxt   = RF_ADDR;
        rf_wdata_nxt  = RF_WR_DATA;
        rsp_valid_nxt = (state_nxt == RSP);
        rsp_data_nxt  = RSP_DATA;
        rsp_addr_nxt  = RSP_ADDR;
        done_nxt      = (state != IDLE) && (state_nxt == IDLE);
        if (wr_en_nxt || rd_en_nxt) begin
            rf_addr_nxt = addr_nxt;
        end
        if (wr_en_nxt) begin
            rf_wdata_nxt = wdata_nxt;
        end
        if (state == RD_WAIT) begin
            rsp_data_nxt = RF_RD_DATA;
            rsp_addr_nxt = addr;
        end
    end

    // Registered outputs so enables and response fields are glitch-free
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            RF_ADDR    <= '0;
            RF_WR_DATA <= '0;
            RSP_VALID  <= 1'b0;
            RSP_DATA   <= '0;
            RSP_ADDR   <= '0;
            DONE       <= 1'b0;
        end else begin
            RF_WR_EN   <= wr_en_nxt;
            RF_RD_EN   <= rd_en_nxt;
            RF_ADDR    <= rf_addr_nxt;
            RF_WR_DATA <= rf_wdata_nxt;
            RSP_VALID  <= rsp_valid_nxt;
            RSP_DATA   <= rsp_data_nxt;
            RSP_ADDR   <= rsp_addr_nxt;
            DONE       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file_master.sv
// tb_reg_file_master: directed and random bursts against a register-file
// model and an array-level reference of what the register file should hold.
module tb_reg_file_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [2:0]  CMD_ADDR;
    logic [2:0]  CMD_LEN;
    logic [15:0] CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [15:0] RSP_DATA;
    logic [2:0]  RSP_ADDR;
    logic        DONE;
    logic        BUSY;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [2:0]  RF_ADDR;
    logic [15:0] RF_WR_DATA;
    logic [15:0] RF_RD_DATA;

    int n_vec = 0;
    int n_err = 0;

    int wr_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    logic        preload;
    logic [15:0] seed_vals [0:7];
    logic [15:0] rf_mem [0:7];
    logic [15:0] ref_mem [0:7];

    reg_file_master dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_WRITE  (CMD_WRITE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_LEN    (CMD_LEN),
        .CMD_WDATA  (CMD_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_DATA   (RSP_DATA),
        .RSP_ADDR   (RSP_ADDR),
        .DONE       (DONE),
        .BUSY       (BUSY),
        .RF_WR_EN   (RF_WR_EN),
        .RF_RD_EN   (RF_RD_EN),
        .RF_ADDR    (RF_ADDR),
        .RF_WR_DATA (RF_WR_DATA),
        .RF_RD_DATA (RF_RD_DATA)
    );

    always #5 CLK = ~CLK;

    // Register file: synchronous write, registered read, not reset by RST
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= seed_vals[i];
        end else begin
            if (RF_WR_EN) rf_mem[RF_ADDR] <= RF_WR_DATA;
            if (RF_RD_EN) RF_RD_DATA <= rf_mem[RF_ADDR];
        end
    end

    // Event counters sampled mid-cycle
    always @(negedge CLK) begin
        if (RF_WR_EN === 1'b1) wr_cnt++;
        if (RF_RD_EN === 1'b1) rd_cnt++;
        if (DONE === 1'b1) done_cnt++;
        if (RF_WR_EN === 1'b1 && RF_RD_EN === 1'b1) overlap_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic scramble_cmd();
        CMD_WRITE = 1'($urandom);
        CMD_ADDR  = 3'($urandom);
        CMD_LEN   = 3'($urandom);
        CMD_WDATA = 16'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, CMD_READY, 1);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_rsp_valid"}, RSP_VALID, 0);
        check({tag, "_rsp_data"}, RSP_DATA, 0);
        check({tag, "_rsp_addr"}, RSP_ADDR, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_wr_en"}, RF_WR_EN, 0);
        check({tag, "_rd_en"}, RF_RD_EN, 0);
        check({tag, "_rf_addr"}, RF_ADDR, 0);
        check({tag, "_rf_wdata"}, RF_WR_DATA, 0);
    endtask

    // Present a command when ready; returns just after the accept edge
    task automatic issue(input logic wr, input logic [2:0] a,
                         input logic [2:0] l, input logic [15:0] d,
                         input bit hold);
        int waited = 0;
        while (CMD_READY !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check("cmd_ready_wait", CMD_READY, 1);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = a;
        CMD_LEN   = l;
        CMD_WDATA = d;
        step();
        if (!hold) begin
            CMD_VALID = 1'b0;
            scramble_cmd();
        end
    endtask

    // Checks the write beats; returns in the DONE cycle
    task automatic write_body(input logic [2:0] a, input logic [2:0] l,
                              input logic [15:0] d);
        int w0 = wr_cnt;
        logic [2:0] ba = a;
        for (int i = 0; i <= int'(l); i++) begin
            ba = a + 3'(i);
            check("wr_en", RF_WR_EN, 1);
            check("wr_rd_en", RF_RD_EN, 0);
            check("wr_addr", RF_ADDR, ba);
            check("wr_data", RF_WR_DATA, d);
            check("wr_cmd_ready", CMD_READY, 0);
            check("wr_done", DONE, 0);
            ref_mem[ba] = d;
            step();
        end
        check("wr_end_done", DONE, 1);
        check("wr_end_en", RF_WR_EN, 0);
        check("wr_end_ready", CMD_READY, 1);
        check("wr_end_busy", BUSY, 0);
        check("wr_end_addr_hold", RF_ADDR, ba);
        check("wr_end_data_hold", RF_WR_DATA, d);
        check("wr_beats", wr_cnt - w0, int'(l) + 1);
    endtask

    // Checks request/wait/response per beat; returns in the DONE cycle
    task automatic read_body(input logic [2:0] a, input logic [2:0] l,
                             input int stall_beat, input int stall_n);
        int r0 = rd_cnt;
        logic [2:0] ba;
        for (int i = 0; i <= int'(l); i++) begin
            ba = a + 3'(i);
            check("rd_req_en", RF_RD_EN, 1);
            check("rd_req_wr_en", RF_WR_EN, 0);
            check("rd_req_addr", RF_ADDR, ba);
            check("rd_req_ready", CMD_READY, 0);
            check("rd_req_valid", RSP_VALID, 0);
            step();
            check("rd_wait_en", RF_RD_EN, 0);
            check("rd_wait_valid", RSP_VALID, 0);
            step();
            check("rsp_valid", RSP_VALID, 1);
            check("rsp_data", RSP_DATA, ref_mem[ba]);
            check("rsp_addr", RSP_ADDR, ba);
            check("rsp_rd_en", RF_RD_EN, 0);
            if (i == stall_beat) begin
                RSP_READY = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    check("stall_valid", RSP_VALID, 1);
                    check("stall_data", RSP_DATA, ref_mem[ba]);
                    check("stall_addr", RSP_ADDR, ba);
                    check("stall_rd_en", RF_RD_EN, 0);
                    check("stall_done", DONE, 0);
                end
                RSP_READY = 1'b1;
            end
            step();
        end
        check("rd_end_done", DONE, 1);
        check("rd_end_valid", RSP_VALID, 0);
        check("rd_end_ready", CMD_READY, 1);
        check("rd_pulses", rd_cnt - r0, int'(l) + 1);
    endtask

    initial begin
        int d0;
        int snap_wr;
        int snap_rd;
        int snap_done;
        int exp_wr;
        int exp_rd;
        int exp_done;
        logic       r_wr;
        logic [2:0] r_a;
        logic [2:0] r_l;
        logic [15:0] r_d;

        RST       = 1'b1;
        CMD_VALID = 1'b0;
        RSP_READY = 1'b1;
        preload   = 1'b1;
        scramble_cmd();
        for (int i = 0; i < 8; i++) begin
            seed_vals[i] = 16'($urandom);
            ref_mem[i]   = seed_vals[i];
        end
        step();
        step();
        preload = 1'b0;

        // reset state while RST held
        check_reset_outputs("por");
        #3 RST = 1'b0;
        step();
        check("idle_ready", CMD_READY, 1);

        // asynchronous reset while a read response is pending
        issue(1'b0, 3'd5, 3'd2, 16'h0, 1'b0);
        step();
        step();
        check("pre_rst_valid", RSP_VALID, 1);
        #2 RST = 1'b1;
        #1;
        check_reset_outputs("async");
        step();
        #3 RST = 1'b0;
        step();

        // single write then single read
        issue(1'b1, 3'd0, 3'd0, 16'h000F, 1'b0);
        write_body(3'd0, 3'd0, 16'h000F);
        step();
        check("done_one_cycle", DONE, 0);
        issue(1'b0, 3'd0, 3'd0, 16'h0, 1'b0);
        read_body(3'd0, 3'd0, -1, 0);
        step();

        // fill burst wrapping 6,7,0,1
        issue(1'b1, 3'd6, 3'd3, 16'hFFFF, 1'b0);
        write_body(3'd6, 3'd3, 16'hFFFF);
        step();

        // read burst with a 4-cycle stall on the second beat
        d0 = done_cnt;
        issue(1'b0, 3'd6, 3'd3, 16'h0, 1'b0);
        read_body(3'd6, 3'd3, 1, 4);
        step();
        check("rd_burst_single_done", done_cnt - d0, 1);

        // reset after three beats of an 8-beat write
        d0 = done_cnt;
        issue(1'b1, 3'd0, 3'd7, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("mid_wr_en", RF_WR_EN, 1);
            check("mid_wr_addr", RF_ADDR, 3'(i));
            ref_mem[i] = 16'h1234;
            step();
        end
        check("mid_beat3_en", RF_WR_EN, 1);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_wr_en", RF_WR_EN, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_ready", CMD_READY, 1);
        step();
        #3 RST = 1'b0;
        step();
        step();
        check("mid_rst_no_done", done_cnt - d0, 0);
        issue(1'b0, 3'd3, 3'd0, 16'h0, 1'b0);
        read_body(3'd3, 3'd0, -1, 0);
        step();

        // back-to-back: read queued behind a write with CMD_VALID held
        issue(1'b1, 3'd4, 3'd1, 16'hA5C3, 1'b1);
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 3'd4;
        CMD_LEN   = 3'd1;
        CMD_WDATA = 16'h0;
        write_body(3'd4, 3'd1, 16'hA5C3);
        step();
        CMD_VALID = 1'b0;
        scramble_cmd();
        check("b2b_accepted_busy", BUSY, 1);
        read_body(3'd4, 3'd1, -1, 0);
        step();

        // random commands, each issued from the previous DONE cycle
        snap_wr   = wr_cnt;
        snap_rd   = rd_cnt;
        snap_done = done_cnt;
        exp_wr    = 0;
        exp_rd    = 0;
        exp_done  = 0;
        for (int n = 0; n < 40; n++) begin
            r_wr = 1'($urandom);
            r_a  = 3'($urandom);
            r_l  = 3'($urandom);
            r_d  = 16'($urandom);
            issue(r_wr, r_a, r_l, r_d, 1'b0);
            if (r_wr) begin
                write_body(r_a, r_l, r_d);
                exp_wr += int'(r_l) + 1;
            end else begin
                read_body(r_a, r_l, int'($urandom_range(0, 9)),
                          int'($urandom_range(1, 3)));
                exp_rd += int'(r_l) + 1;
            end
            exp_done++;
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("gap_done_low", DONE, 0);
            end
        end
        step();
        check("rand_wr_total", wr_cnt - snap_wr, exp_wr);
        check("rand_rd_total", rd_cnt - snap_rd, exp_rd);
        check("rand_done_total", done_cnt - snap_done, exp_done);
        check("never_both_enables", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
